mem_arbiter: RTL and testbench

Two-master arbiter that shares the single unified memory (`mem`) between two requesters: the multi-cycle core's memory port and a second master (loader/DMA or split fetch port). It accepts a request/acknowledge handshake from each master, selects a winner, drives the memory's address, write data and `MemRead`/`MemWrite` strobes for a fixed access latency, registers read data, and returns a single-cycle acknowledge. It sits between the masters and `mem`, replacing the direct core-to-memory wiring.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : two-master arbiter sharing one unified memory port (IDLE -> ACCESS -> RESP).
// Latency : request sampled in IDLE -> one-cycle ack MEM_LAT+1 cycles later; one access per MEM_LAT+2 cycles.
// Backpr. : masters hold req until ack; requests are only sampled in IDLE, the loser keeps req high and waits.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   m{0,1}_req/we/addr/wdata     master request fields (held until ack)
//   m{0,1}_gnt                   master owns memory (ACCESS and RESP)
//   m{0,1}_ack                   one-cycle completion pulse
//   m{0,1}_rdata                 registered read data, held until that master's next read
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata   memory side
//
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating tie-break
// (master other than the last winner wins); default is fixed priority, m0 wins ties.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               win;        // current owner: 0 = m0, 1 = m1
  logic               last;       // owner of the most recently completed access
  logic               pick;       // arbitration result in IDLE: 0 = m0, 1 = m1
  logic               acc_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [CNT_W-1:0]   cnt;

  // Tie-break: round robin favours the master that did not win last time
  // (last resets to 1 so m0 wins the first tie); fixed priority favours m0.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = RR_EN ? ~last : 1'b0;
    end else begin
      pick = ~m0_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes, grants and acks decode straight from state so an asynchronous
  // reset drops them immediately without waiting for a clock edge.
  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        m0_gnt    = ~win;
        m1_gnt    = win;
        mem_read  = ~acc_we;
        mem_write = acc_we;
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        m0_gnt    = ~win;
        m1_gnt    = win;
        m0_ack    = ~win;
        m1_ack    = win;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request fields are latched at grant time so later master-side changes
  // cannot disturb the memory during ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win       <= 1'b0;
      last      <= 1'b1;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      cnt       <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            win       <= pick;
            acc_we    <= pick ? m1_we    : m0_we;
            acc_addr  <= pick ? m1_addr  : m0_addr;
            acc_wdata <= pick ? m1_wdata : m0_wdata;
            cnt       <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!acc_we) begin
              if (win) begin
                m1_rdata <= mem_rdata;
              end else begin
                m0_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          last <= win;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter; u_a runs MEM_LAT=1, u_b runs MEM_LAT=3.
// Latency : expected completions are queued at issue time and popped by a monitor on every ack.
// Backpr. : bench masters hold req until they sample ack, then drop it on that edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst     [2];
  logic        preload;
  logic        req     [2][2];
  logic        we      [2][2];
  logic [63:0] addr    [2][2];
  logic [63:0] wdata   [2][2];
  logic        gnt     [2][2];
  logic        ack     [2][2];
  logic [63:0] rdata   [2][2];
  logic [63:0] mem_addr  [2];
  logic [63:0] mem_wdata [2];
  logic [63:0] mem_rdata [2];
  logic        mem_read  [2];
  logic        mem_write [2];

  bit [63:0]   mema [16];
  bit [63:0]   memb [16];

  typedef struct {
    int          m;
    logic [63:0] rd;
  } exp_t;

  exp_t expq [2][$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cycle  = 0;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst[0]),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_gnt(gnt[0][0]), .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_gnt(gnt[0][1]), .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst[1]),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_gnt(gnt[1][0]), .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_gnt(gnt[1][1]), .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Memory models: combinational read, write on the clock edge while mem_write is high.
  assign mem_rdata[0] = mema[mem_addr[0][6:3]];
  assign mem_rdata[1] = memb[mem_addr[1][6:3]];

  always @(posedge clk) begin
    if (preload) mema[8] <= 64'hDEADBEEF;
    else if (mem_write[0]) mema[mem_addr[0][6:3]] <= mem_wdata[0];
  end

  always @(posedge clk) begin
    if (mem_write[1]) memb[mem_addr[1][6:3]] <= mem_wdata[1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    chk(name, {63'd0, act}, {63'd0, want});
  endtask

  task automatic push_exp(input int d, input int m, input logic [63:0] rd);
    exp_t e;
    e.m  = m;
    e.rd = rd;
    expq[d].push_back(e);
  endtask

  // Scoreboard monitor: every ack pops the next expected completion of that DUT.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        if (ack[d][m] === 1'b1) begin
          if (expq[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ack dut%0d m%0d: ack=1, required no completion pending", d, m);
          end else begin
            exp_t e;
            e = expq[d].pop_front();
            chk("ack_master", 64'(m), 64'(e.m));
            chk("ack_rdata", rdata[d][m], e.rd);
          end
        end
      end
    end
  end

  task automatic wait_ack(input int d, input int m, output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack[d][m] === 1'b1) break;
    end
  endtask

  task automatic drop_req(input int d, input int m);
    @(posedge clk);
    #1 req[d][m] = 1'b0;
  endtask

  // One access from an idle DUT; starts and ends on a negedge.
  // new_a is applied to the master's address after the first strobe cycle.
  task automatic run_single(input int d, input int m, input logic w, input logic [63:0] a,
                            input logic [63:0] wd, input int lat, input logic [63:0] rd,
                            input logic [63:0] new_a);
    int cyc     = 0;
    int strobes = 0;
    bit got     = 0;
    push_exp(d, m, rd);
    we[d][m]    = w;
    addr[d][m]  = a;
    wdata[d][m] = wd;
    req[d][m]   = 1'b1;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_read[d] | mem_write[d]) begin
        strobes++;
        chk1("strobe_write", mem_write[d], w);
        chk1("strobe_gnt", gnt[d][m], 1'b1);
        chk("mem_addr", mem_addr[d], a);
        if (w) chk("mem_wdata", mem_wdata[d], wd);
        addr[d][m] = new_a;
      end
      if (ack[d][m] === 1'b1) got = 1;
    end
    chk1("ack_seen", got, 1'b1);
    chk("latency", 64'(cyc), 64'(lat + 1));
    chk("strobe_cycles", 64'(strobes), 64'(lat));
    drop_req(d, m);
    @(negedge clk);
    chk1("ack_one_cycle", ack[d][m], 1'b0);
    chk1("gnt_release", gnt[d][m], 1'b0);
  endtask

  initial begin
    int cyc;
    int n_ack;
    int prev_cyc;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
      end
    end
    preload = 1'b1;

    // Reset held low with both requests high: every output must sit at 0.
    req[0][0] = 1'b1; addr[0][0] = 64'h0;
    req[0][1] = 1'b1; addr[0][1] = 64'h40;
    #18;
    preload = 1'b0;
    chk1("rst_m0_gnt", gnt[0][0], 1'b0);
    chk1("rst_m1_gnt", gnt[0][1], 1'b0);
    chk1("rst_m0_ack", ack[0][0], 1'b0);
    chk1("rst_m1_ack", ack[0][1], 1'b0);
    chk1("rst_mem_read", mem_read[0], 1'b0);
    chk1("rst_mem_write", mem_write[0], 1'b0);
    chk("rst_mem_addr", mem_addr[0], 64'h0);
    chk("rst_mem_wdata", mem_wdata[0], 64'h0);
    chk("rst_m0_rdata", rdata[0][0], 64'h0);
    chk("rst_m1_rdata", rdata[0][1], 64'h0);
    @(negedge clk);
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    // First tie after reset goes to m0; m1 is served next.
    push_exp(0, 0, 64'h0);
    push_exp(0, 1, 64'hDEADBEEF);
    @(negedge clk);
    chk1("first_gnt_m0", gnt[0][0], 1'b1);
    chk1("first_gnt_m1", gnt[0][1], 1'b0);
    chk1("first_mem_read", mem_read[0], 1'b1);
    wait_ack(0, 0, cyc);
    chk("first_latency", 64'(cyc + 1), 64'd2);
    drop_req(0, 0);
    wait_ack(0, 1, cyc);
    chk("loser_served", 64'(cyc), 64'd3);
    drop_req(0, 1);
    @(negedge clk);

    // Write then read on m0; the write leaves m0_rdata at its previous value.
    run_single(0, 0, 1'b1, 64'h8, 64'h1234, 1, 64'h0, 64'h8);
    run_single(0, 0, 1'b0, 64'h8, 64'h0, 1, 64'h1234, 64'h8);
    // Single read of 0x40 by m1 (m1 is then the last winner).
    run_single(0, 1, 1'b0, 64'h40, 64'h0, 1, 64'hDEADBEEF, 64'h40);

    // Sustained contention: each master drops req once 4 acks have been seen in total.
`ifdef ARB_ROUND_ROBIN_EN
    push_exp(0, 0, 64'h1234); push_exp(0, 1, 64'hDEADBEEF);
    push_exp(0, 0, 64'h1234); push_exp(0, 1, 64'hDEADBEEF);
    push_exp(0, 0, 64'h1234);
`else
    push_exp(0, 0, 64'h1234); push_exp(0, 0, 64'h1234);
    push_exp(0, 0, 64'h1234); push_exp(0, 0, 64'h1234);
    push_exp(0, 1, 64'hDEADBEEF);
`endif
    we[0][0] = 1'b0; addr[0][0] = 64'h8;
    we[0][1] = 1'b0; addr[0][1] = 64'h40;
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    n_ack = 0;
    prev_cyc = 0;
    cyc = 0;
    while ((req[0][0] || req[0][1]) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      for (int m = 0; m < 2; m++) begin
        if (ack[0][m] === 1'b1) begin
          n_ack++;
          if (n_ack > 1) chk("contention_period", 64'(cycle - prev_cyc), 64'd3);
          prev_cyc = cycle;
          if (n_ack >= 4) drop_req(0, m);
        end
      end
    end
    chk("contention_acks", 64'(n_ack), 64'd5);
    @(negedge clk);

    // Reset in the middle of an access: strobes and grant fall at once, rdata clears.
    we[0][1] = 1'b0; addr[0][1] = 64'h40; req[0][1] = 1'b1;
    @(negedge clk);
    chk1("midrst_strobe_before", mem_read[0], 1'b1);
    #2 rst[0] = 1'b0;
    #1;
    chk1("midrst_strobe_drop", mem_read[0], 1'b0);
    chk1("midrst_gnt_drop", gnt[0][1], 1'b0);
    chk("midrst_rdata_clear", rdata[0][1], 64'h0);
    @(negedge clk);
    chk1("midrst_no_ack", ack[0][1], 1'b0);
    rst[0] = 1'b1;
    push_exp(0, 1, 64'hDEADBEEF);
    wait_ack(0, 1, cyc);
    chk("midrst_reservice", 64'(cyc), 64'd2);
    drop_req(0, 1);
    @(negedge clk);

    // MEM_LAT=3: three strobe cycles; address change during ACCESS must not reach memory.
    run_single(1, 0, 1'b1, 64'h10, 64'h55, 3, 64'h0, 64'h10);
    run_single(1, 0, 1'b0, 64'h10, 64'h0, 3, 64'h55, 64'h18);
    run_single(1, 1, 1'b0, 64'h10, 64'h0, 3, 64'h55, 64'h10);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(expq[0].size() + expq[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
